prio_encoder: RTL and testbench
===============================

PRIO_ENCODER -- requirements
Module: prio_encoder

Interface
REQ-001 Parameter N, default 8: input vector width; SHALL be a power of two, 2..64.
REQ-002 Parameter MSB_FIRST, default 0: 0 = lowest set index wins, 1 = highest set index wins.
REQ-003 Derived constant W = log2(N), width of the encoded index.
REQ-004 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 RST_N  input  1  reset; asynchronous and active-low.
REQ-006 IN_VALID  input  1  F is valid this cycle.
REQ-007 IN_READY  output  1  block accepts F this cycle.
REQ-008 F  input  N  request vector.
REQ-009 OUT_VALID  output  1  A/NONE/MULTI hold a result.
REQ-010 OUT_READY  input  1  consumer takes the result this cycle.
REQ-011 A  output  W  encoded index of the winning bit.
REQ-012 NONE  output  1  accepted F was all-zero.
REQ-013 MULTI  output  1  accepted F had more than one bit set (present only with PRIO_ENCODER_CHECK_EN).
REQ-014 ERR_STICKY  output  1  latched multi-hot error (present only with PRIO_ENCODER_CHECK_EN).
REQ-015 ERR_CLR  input  1  synchronous clear of ERR_STICKY (present only with PRIO_ENCODER_CHECK_EN).

Function
REQ-016 Transfer in SHALL occur on a rising edge where IN_VALID and IN_READY are both 1.
REQ-017 Transfer out SHALL occur on a rising edge where OUT_VALID and OUT_READY are both 1.
REQ-018 IN_READY SHALL equal (not OUT_VALID) or OUT_READY, combinationally; no other input-to-output combinational path.
REQ-019 Latency SHALL be one cycle: a result accepted at edge k appears on A/NONE/MULTI with OUT_VALID=1 after edge k.
REQ-020 Simultaneous in and out transfer SHALL replace the result in the same edge with OUT_VALID staying 1; full throughput of one word per cycle.
REQ-021 When OUT_VALID=1 and OUT_READY=0, A/NONE/MULTI SHALL hold stable and IN_READY SHALL be 0.
REQ-022 Out transfer with no in transfer SHALL clear OUT_VALID; A/NONE/MULTI keep their last value.
REQ-023 With MSB_FIRST=0, A SHALL be the index of the lowest set bit of F; with MSB_FIRST=1, the highest.
REQ-024 F all-zero SHALL give A=0, NONE=1; otherwise NONE=0.
REQ-025 Output state machine: EMPTY (OUT_VALID=0) -> FULL on in transfer; FULL -> EMPTY on out-without-in; FULL -> FULL on in or on stall.
REQ-026 Exactly-one-hot F SHALL encode identically in both MSB_FIRST settings.

Reset
REQ-027 RST_N low SHALL force immediately, regardless of CLK: OUT_VALID=0, A=0, NONE=0, MULTI=0, ERR_STICKY=0.
REQ-028 Reset asserted mid-transfer SHALL discard the held result; the first edge after release SHALL accept input.

Configuration
REQ-029 Macro PRIO_ENCODER_CHECK_EN defined: MULTI, ERR_STICKY and ERR_CLR SHALL exist.
  - MULTI registered with A.
  - ERR_STICKY set on any in transfer with multi-hot F.
  - ERR_CLR clears ERR_STICKY; a set in the same cycle wins over clear.
REQ-030 Macro undefined: those three ports and their logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-031 Shared package prio_encoder_pkg SHALL hold the log2 width function and the MSB_FIRST encoding constants.
REQ-032 Combinational encode SHALL be a sub-module prio_encoder_core (F in; A, NONE, MULTI out); prio_encoder holds the handshake register and sticky flag.

Verification
REQ-033 N=8, MSB_FIRST=0, OUT_READY=1, F=8'b0010_1100 -> next cycle A=2, NONE=0, MULTI=1 (CHECK_EN).
REQ-034 N=8, MSB_FIRST=1, same F -> A=5; F=8'h00 -> A=0, NONE=1.
REQ-035 OUT_READY=0 for 3 cycles after one accepted word -> IN_READY=0, A stable; OUT_READY=1 -> word taken, next input accepted the same edge.
REQ-036 Back-to-back F=8'h01,8'h02,8'h80 with OUT_READY=1 -> A=0,1,7 on consecutive cycles, OUT_VALID continuously 1.
REQ-037 Multi-hot accepted in the same cycle as ERR_CLR=1 -> ERR_STICKY=1; ERR_CLR next cycle alone -> 0.
REQ-038 RST_N pulsed low between edges while FULL -> OUT_VALID=0 immediately; IN_READY=1.

Source files
------------

// File: rtl/prio_encoder_pkg.sv
// Shared constants and helpers for the priority encoder.
// Optional multi-hot checking is enabled with the PRIO_ENCODER_CHECK_EN macro.
package prio_encoder_pkg;

  localparam int unsigned LsbFirst = 0;
  localparam int unsigned MsbFirst = 1;

  typedef enum logic {
    StEmpty,
    StFull
  } out_state_e;

  // Width of an index into an n-wide vector (n is a power of two).
  function automatic int unsigned log2w(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_encoder_core.sv
// Combinational priority encode of a request vector.
// The multi-hot flag exists only when PRIO_ENCODER_CHECK_EN is defined.
module prio_encoder_core
  import prio_encoder_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned MSB_FIRST = LsbFirst,
  localparam int unsigned W        = log2w(N)
) (
  input  logic [N-1:0] f,
  output logic [W-1:0] a,
`ifdef PRIO_ENCODER_CHECK_EN
  output logic         multi,
`endif
  output logic         none
);

  always_comb begin
    int   idx;
    logic found;
    a     = '0;
    found = 1'b0;
    idx   = 0;
    // Scan in priority order; the first set bit seen wins.
    for (int i = 0; i < int'(N); i++) begin
      idx = (MSB_FIRST == MsbFirst) ? (int'(N) - 1 - i) : i;
      if (f[idx] && !found) begin
        a     = idx[W-1:0];
        found = 1'b1;
      end
    end
  end

  assign none = ~|f;

`ifdef PRIO_ENCODER_CHECK_EN
  // Clearing the lowest set bit leaves something only if more than one was set.
  assign multi = |(f & (f - N'(1)));
`endif

endmodule

// File: rtl/prio_encoder.sv
// Priority encoder with a one-deep valid/ready output register.
// PRIO_ENCODER_CHECK_EN adds the multi-hot flag, sticky error and its clear.
module prio_encoder
  import prio_encoder_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned MSB_FIRST = LsbFirst,
  localparam int unsigned W        = log2w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] f,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a,
`ifdef PRIO_ENCODER_CHECK_EN
  output logic         multi,
  output logic         err_sticky,
  input  logic         err_clr,
`endif
  output logic         none
);

  out_state_e   st_q;
  logic [W-1:0] a_q;
  logic         none_q;
  logic [W-1:0] core_a;
  logic         core_none;
  logic         in_xfer;
  logic         out_xfer;

`ifdef PRIO_ENCODER_CHECK_EN
  logic core_multi;
  logic multi_q;
  logic err_q;
`endif

  prio_encoder_core #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .f     (f),
    .a     (core_a),
`ifdef PRIO_ENCODER_CHECK_EN
    .multi (core_multi),
`endif
    .none  (core_none)
  );

  assign out_valid = (st_q == StFull);
  assign in_ready  = ~out_valid | out_ready;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= StEmpty;
      a_q    <= '0;
      none_q <= 1'b0;
`ifdef PRIO_ENCODER_CHECK_EN
      multi_q <= 1'b0;
`endif
    end else if (in_xfer) begin
      st_q   <= StFull;
      a_q    <= core_a;
      none_q <= core_none;
`ifdef PRIO_ENCODER_CHECK_EN
      multi_q <= core_multi;
`endif
    end else if (out_xfer) begin
      // Result fields keep their last value once drained.
      st_q <= StEmpty;
    end
  end

  assign a    = a_q;
  assign none = none_q;

`ifdef PRIO_ENCODER_CHECK_EN
  // A new multi-hot word outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (in_xfer && core_multi) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign multi      = multi_q;
  assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_prio_encoder.sv
// Directed bench for prio_encoder: LSB-first and MSB-first instances share stimulus.
// Checks of the optional outputs follow PRIO_ENCODER_CHECK_EN.
module tb_prio_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] f;
  logic       err_clr;

  logic       in_ready_l, out_valid_l, none_l;
  logic       in_ready_m, out_valid_m, none_m;
  logic [2:0] a_l, a_m;
  logic       multi_l, err_l, multi_m, err_m;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  prio_encoder #(.N(8), .MSB_FIRST(0)) u_dut_lsb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready_l),
    .f          (f),
    .out_valid  (out_valid_l),
    .out_ready  (out_ready),
    .a          (a_l),
`ifdef PRIO_ENCODER_CHECK_EN
    .multi      (multi_l),
    .err_sticky (err_l),
    .err_clr    (err_clr),
`endif
    .none       (none_l)
  );

  prio_encoder #(.N(8), .MSB_FIRST(1)) u_dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready_m),
    .f          (f),
    .out_valid  (out_valid_m),
    .out_ready  (out_ready),
    .a          (a_m),
`ifdef PRIO_ENCODER_CHECK_EN
    .multi      (multi_m),
    .err_sticky (err_m),
    .err_clr    (err_clr),
`endif
    .none       (none_m)
  );

`ifndef PRIO_ENCODER_CHECK_EN
  assign multi_l = 1'b0;
  assign err_l   = 1'b0;
  assign multi_m = 1'b0;
  assign err_m   = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; f = 8'h00; err_clr = 1'b0;
    #2;
    n_checks++;
    if (out_valid_l !== 1'b0 || a_l !== 3'd0 || none_l !== 1'b0 || err_l !== 1'b0)
      $display("FAIL reset_lsb: ov=%b a=%0d none=%b err=%b, want 0 0 0 0",
               out_valid_l, a_l, none_l, err_l);
    else n_pass++;
    n_checks++;
    if (out_valid_m !== 1'b0 || a_m !== 3'd0 || in_ready_m !== 1'b1)
      $display("FAIL reset_msb: ov=%b a=%0d rdy=%b, want 0 0 1", out_valid_m, a_m, in_ready_m);
    else n_pass++;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_encode();
    f = 8'b0010_1100; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid_l !== 1'b1 || a_l !== 3'd2 || none_l !== 1'b0)
      $display("FAIL enc_lsb_2c: ov=%b a=%0d none=%b, want 1 2 0", out_valid_l, a_l, none_l);
    else n_pass++;
    n_checks++;
    if (a_m !== 3'd5 || none_m !== 1'b0)
      $display("FAIL enc_msb_2c: a=%0d none=%b, want 5 0", a_m, none_m);
    else n_pass++;
`ifdef PRIO_ENCODER_CHECK_EN
    n_checks++;
    if (multi_l !== 1'b1 || err_l !== 1'b1)
      $display("FAIL multi_2c: multi=%b err=%b, want 1 1", multi_l, err_l);
    else n_pass++;
`endif
    f = 8'h00; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (a_m !== 3'd0 || none_m !== 1'b1 || a_l !== 3'd0 || none_l !== 1'b1)
      $display("FAIL enc_zero: a_l=%0d none_l=%b a_m=%0d none_m=%b, want 0 1 0 1",
               a_l, none_l, a_m, none_m);
    else n_pass++;
    f = 8'h10;
    step();
    n_checks++;
    if (out_valid_l !== 1'b0 || none_l !== 1'b1 || a_l !== 3'd0)
      $display("FAIL drain_hold: ov=%b none=%b a=%0d, want 0 1 0", out_valid_l, none_l, a_l);
    else n_pass++;
  endtask

  task automatic test_stall();
    f = 8'h08; in_valid = 1'b1; out_ready = 1'b0;
    step();
    f = 8'h40;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready_l !== 1'b0 || a_l !== 3'd3 || out_valid_l !== 1'b1)
        $display("FAIL stall_%0d: rdy=%b a=%0d ov=%b, want 0 3 1", i, in_ready_l, a_l, out_valid_l);
      else n_pass++;
      step();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready_l !== 1'b1)
      $display("FAIL stall_release_rdy: rdy=%b, want 1", in_ready_l);
    else n_pass++;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid_l !== 1'b1 || a_l !== 3'd6 || a_m !== 3'd6)
      $display("FAIL stall_replace: ov=%b a_l=%0d a_m=%0d, want 1 6 6", out_valid_l, a_l, a_m);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [3];
    logic [2:0] exp [3];
    vec[0] = 8'h01; vec[1] = 8'h02; vec[2] = 8'h80;
    exp[0] = 3'd0;  exp[1] = 3'd1;  exp[2] = 3'd7;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f = vec[i];
      step();
      n_checks++;
      if (out_valid_l !== 1'b1 || a_l !== exp[i] || a_m !== exp[i])
        $display("FAIL b2b_%0d: ov=%b a_l=%0d a_m=%0d, want 1 %0d %0d",
                 i, out_valid_l, a_l, a_m, exp[i], exp[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
    step();
  endtask

`ifdef PRIO_ENCODER_CHECK_EN
  task automatic test_sticky();
    err_clr = 1'b1;
    step();
    n_checks++;
    if (err_l !== 1'b0) $display("FAIL sticky_clear0: err=%b, want 0", err_l);
    else n_pass++;
    f = 8'h03; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (err_l !== 1'b1 || multi_l !== 1'b1 || err_m !== 1'b1)
      $display("FAIL sticky_set_wins: err=%b multi=%b err_m=%b, want 1 1 1", err_l, multi_l, err_m);
    else n_pass++;
    step();
    err_clr = 1'b0;
    n_checks++;
    if (err_l !== 1'b0) $display("FAIL sticky_clear1: err=%b, want 0", err_l);
    else n_pass++;
    f = 8'h20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (err_l !== 1'b0 || multi_l !== 1'b0)
      $display("FAIL sticky_onehot: err=%b multi=%b, want 0 0", err_l, multi_l);
    else n_pass++;
    step();
  endtask
`endif

  task automatic test_async_reset();
    f = 8'h04; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid_l !== 1'b1 || a_l !== 3'd2)
      $display("FAIL pre_reset_full: ov=%b a=%0d, want 1 2", out_valid_l, a_l);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid_l !== 1'b0 || a_l !== 3'd0 || in_ready_l !== 1'b1 || out_valid_m !== 1'b0)
      $display("FAIL async_reset: ov=%b a=%0d rdy=%b ov_m=%b, want 0 0 1 0",
               out_valid_l, a_l, in_ready_l, out_valid_m);
    else n_pass++;
    #1 rst_n = 1'b1;
    f = 8'h20; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid_l !== 1'b1 || a_l !== 3'd5)
      $display("FAIL post_reset_accept: ov=%b a=%0d, want 1 5", out_valid_l, a_l);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_encode();
    test_stall();
    test_back_to_back();
`ifdef PRIO_ENCODER_CHECK_EN
    test_sticky();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
